// File: rtl/network_sdiv_30s_16s_16_seq_pkg.sv
// Shared types and width constants for the sequential signed divider.
package network_div_pkg;

   localparam int DIVIDEND_WIDTH_DEF = 30;
   localparam int DIVISOR_WIDTH_DEF  = 16;
   localparam int QUOT_WIDTH_DEF     = 16;
   localparam int CNT_WIDTH          = $clog2(DIVIDEND_WIDTH_DEF + 1);

   localparam logic [QUOT_WIDTH_DEF-1:0] QUOT_MAX = {1'b0, {(QUOT_WIDTH_DEF-1){1'b1}}};
   localparam logic [QUOT_WIDTH_DEF-1:0] QUOT_MIN = {1'b1, {(QUOT_WIDTH_DEF-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/network_sdiv_30s_16s_16_seq_if.sv
// Operand/result handshake bundle between the divider and its producer/consumer.
interface network_sdiv_30s_16s_16_seq_if
   import network_div_pkg::*;
#(
   parameter int DIVIDEND_WIDTH = DIVIDEND_WIDTH_DEF,
   parameter int DIVISOR_WIDTH  = DIVISOR_WIDTH_DEF,
   parameter int QUOT_WIDTH     = QUOT_WIDTH_DEF
);
   logic                      in_valid;
   logic                      in_ready;
   logic [DIVIDEND_WIDTH-1:0] dividend;
   logic [DIVISOR_WIDTH-1:0]  divisor;
   logic                      out_valid;
   logic                      out_ready;
   logic [QUOT_WIDTH-1:0]     quotient;
   logic [QUOT_WIDTH-1:0]     remainder;
   logic                      ovf;
   logic                      dz;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, ovf, dz
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, ovf, dz
   );

endinterface

// File: rtl/network_sdiv_30s_16s_16_seq_step.sv
// One unsigned restoring-division iteration: shift in a dividend bit, compare, subtract.
module network_div_restoring_step #(
   parameter int W = 16
) (
   input  logic [W-1:0] prem,
   input  logic         din,
   input  logic [W-1:0] dvs,
   output logic [W-1:0] prem_next,
   output logic         qbit
);
   logic [W:0]   shifted;
   logic [W-1:0] diff;

   assign shifted   = {prem, din};
   assign qbit      = (shifted >= {1'b0, dvs});
   // When qbit is set the true difference is below dvs, so the low W bits suffice.
   assign diff      = shifted[W-1:0] - dvs;
   assign prem_next = qbit ? diff : shifted[W-1:0];

endmodule

// File: rtl/network_sdiv_30s_16s_16_seq.sv
// Sequential signed divider: 30s / 16s -> saturated 16s quotient and 16s remainder.
//   state | meaning
//   IDLE  | waiting for an operand pair
//   CALC  | DIVIDEND_WIDTH restoring steps, then one finalize edge
//   DONE  | result held until the consumer takes it
module network_sdiv_30s_16s_16_seq
   import network_div_pkg::*;
#(
   parameter int DIVIDEND_WIDTH = DIVIDEND_WIDTH_DEF,
   parameter int DIVISOR_WIDTH  = DIVISOR_WIDTH_DEF,
   parameter int QUOT_WIDTH     = QUOT_WIDTH_DEF
) (
   input logic clk,
   input logic reset,
   input logic ce,
   network_sdiv_30s_16s_16_seq_if.slave bus
);
   localparam int CW = $clog2(DIVIDEND_WIDTH + 1);
   localparam logic [CW-1:0]             LAST    = CW'(DIVIDEND_WIDTH);
   localparam logic [DIVIDEND_WIDTH-1:0] POS_LIM = DIVIDEND_WIDTH'((64'd1 << (QUOT_WIDTH-1)) - 64'd1);
   localparam logic [DIVIDEND_WIDTH-1:0] NEG_LIM = DIVIDEND_WIDTH'(64'd1 << (QUOT_WIDTH-1));
   localparam logic [QUOT_WIDTH-1:0]     Q_MAX   = {1'b0, {(QUOT_WIDTH-1){1'b1}}};
   localparam logic [QUOT_WIDTH-1:0]     Q_MIN   = {1'b1, {(QUOT_WIDTH-1){1'b0}}};

   div_state_t                state_q, state_d;
   logic [CW-1:0]             cnt_q;
   logic [DIVIDEND_WIDTH-1:0] dvd_q;
   logic [DIVISOR_WIDTH-1:0]  dvs_q;
   logic [DIVISOR_WIDTH-1:0]  prem_q;
   logic                      qneg_q, rneg_q, dzl_q;
   logic [QUOT_WIDTH-1:0]     quot_q, rem_q;
   logic                      ovf_q, dz_q;

   logic [DIVIDEND_WIDTH-1:0] dvd_abs;
   logic [DIVISOR_WIDTH-1:0]  dvs_abs, prem_nx;
   logic                      qbit;
   logic [QUOT_WIDTH-1:0]     q_fin, r_fin;
   logic                      ovf_fin;

   assign dvd_abs = bus.dividend[DIVIDEND_WIDTH-1] ? (~bus.dividend + DIVIDEND_WIDTH'(1)) : bus.dividend;
   assign dvs_abs = bus.divisor[DIVISOR_WIDTH-1]   ? (~bus.divisor + DIVISOR_WIDTH'(1))   : bus.divisor;

   network_div_restoring_step #(.W(DIVISOR_WIDTH)) u_step (
      .prem      (prem_q),
      .din       (dvd_q[DIVIDEND_WIDTH-1]),
      .dvs       (dvs_q),
      .prem_next (prem_nx),
      .qbit      (qbit)
   );

   // After the last step dvd_q has been fully replaced by the quotient magnitude.
   always_comb begin
      q_fin   = '0;
      ovf_fin = 1'b0;
      r_fin   = rneg_q ? (QUOT_WIDTH'(0) - QUOT_WIDTH'(prem_q)) : QUOT_WIDTH'(prem_q);
      if (dzl_q) begin
         q_fin   = rneg_q ? Q_MIN : Q_MAX;
         ovf_fin = 1'b1;
         r_fin   = '0;
      end else if (qneg_q) begin
         if (dvd_q > NEG_LIM) begin
            q_fin   = Q_MIN;
            ovf_fin = 1'b1;
         end else begin
            q_fin = QUOT_WIDTH'(0) - dvd_q[QUOT_WIDTH-1:0];
         end
      end else if (dvd_q > POS_LIM) begin
         q_fin   = Q_MAX;
         ovf_fin = 1'b1;
      end else begin
         q_fin = dvd_q[QUOT_WIDTH-1:0];
      end
   end

   always_comb begin
      state_d      = state_q;
      bus.in_ready = (state_q == IDLE) && !reset;
      bus.out_valid = (state_q == DONE);
      case (state_q)
         IDLE:    if (ce && bus.in_valid) state_d = CALC;
         CALC:    if (ce && cnt_q == LAST) state_d = DONE;
         DONE:    if (ce && bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         dvd_q  <= '0;
         dvs_q  <= '0;
         prem_q <= '0;
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
         dzl_q  <= 1'b0;
         quot_q <= '0;
         rem_q  <= '0;
         ovf_q  <= 1'b0;
         dz_q   <= 1'b0;
      end else if (ce) begin
         case (state_q)
            IDLE: if (bus.in_valid) begin
               cnt_q  <= '0;
               dvd_q  <= dvd_abs;
               dvs_q  <= dvs_abs;
               prem_q <= '0;
               qneg_q <= bus.dividend[DIVIDEND_WIDTH-1] ^ bus.divisor[DIVISOR_WIDTH-1];
               rneg_q <= bus.dividend[DIVIDEND_WIDTH-1];
               dzl_q  <= (bus.divisor == '0);
            end
            CALC: if (cnt_q != LAST) begin
               dvd_q  <= {dvd_q[DIVIDEND_WIDTH-2:0], qbit};
               prem_q <= prem_nx;
               cnt_q  <= cnt_q + CW'(1);
            end else begin
               quot_q <= q_fin;
               rem_q  <= r_fin;
               ovf_q  <= ovf_fin;
               dz_q   <= dzl_q;
            end
            default: ;
         endcase
      end
   end

   assign bus.quotient  = quot_q;
   assign bus.remainder = rem_q;
   assign bus.ovf       = ovf_q;
   assign bus.dz        = dz_q;

endmodule

// File: tb/tb_network_sdiv_30s_16s_16_seq.sv
// Directed bench for the sequential signed divider: arithmetic, saturation, handshakes, ce and reset.
module tb_network_sdiv_30s_16s_16_seq;
   import network_div_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic ce;
   int   errors = 0;
   int   checks = 0;

   network_sdiv_30s_16s_16_seq_if bus ();

   network_sdiv_30s_16s_16_seq dut (
      .clk   (clk),
      .reset (reset),
      .ce    (ce),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      int a;
      int b;
      int q;
      int r;
      bit o;
      bit z;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input int a, input int b, output logic [15:0] q, output logic [15:0] r,
                         output logic o, output logic z, output int lat);
      int guard;
      guard = 0;
      ce = 1'b1;
      while (!bus.in_ready && guard < 100) begin
         tick();
         guard++;
      end
      bus.dividend = 30'(a);
      bus.divisor  = 16'(b);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 100) begin
         tick();
         lat++;
      end
      q = bus.quotient;
      r = bus.remainder;
      o = bus.ovf;
      z = bus.dz;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ce = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.dividend = '0;
      bus.divisor = '0;
      tick(); tick(); tick();
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_handshake in_ready=%b out_valid=%b expected 0 0", bus.in_ready, bus.out_valid);
      end
      checks++;
      if (bus.quotient !== 16'd0 || bus.remainder !== 16'd0 || bus.ovf !== 1'b0 || bus.dz !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs q=%0d r=%0d ovf=%b dz=%b expected 0 0 0 0",
                  bus.quotient, bus.remainder, bus.ovf, bus.dz);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release in_ready=%b expected 1", bus.in_ready);
      end
   endtask

   task automatic test_divide();
      vec_t        v [10];
      logic [15:0] q, r;
      logic        o, z;
      int          lat;
      v[0] = '{1000, 7, 142, 6, 1'b0, 1'b0};
      v[1] = '{-1000, 7, -142, -6, 1'b0, 1'b0};
      v[2] = '{1000, -7, -142, 6, 1'b0, 1'b0};
      v[3] = '{-1000, -7, 142, -6, 1'b0, 1'b0};
      v[4] = '{300000, 2, 32767, 0, 1'b1, 1'b0};
      v[5] = '{-536870912, -1, 32767, 0, 1'b1, 1'b0};
      v[6] = '{-65536, 2, -32768, 0, 1'b0, 1'b0};
      v[7] = '{5, 0, 32767, 0, 1'b1, 1'b1};
      v[8] = '{-5, 0, -32768, 0, 1'b1, 1'b1};
      v[9] = '{32767, 1, 32767, 0, 1'b0, 1'b0};
      for (int i = 0; i < 10; i++) begin
         run_op(v[i].a, v[i].b, q, r, o, z, lat);
         checks++;
         if (q !== 16'(v[i].q) || r !== 16'(v[i].r)) begin
            errors++;
            $display("FAIL divide[%0d] %0d/%0d q=%0d r=%0d expected q=%0d r=%0d",
                     i, v[i].a, v[i].b, $signed(q), $signed(r), v[i].q, v[i].r);
         end
         checks++;
         if (o !== v[i].o || z !== v[i].z) begin
            errors++;
            $display("FAIL flags[%0d] ovf=%b dz=%b expected ovf=%b dz=%b", i, o, z, v[i].o, v[i].z);
         end
         checks++;
         if (lat !== 31) begin
            errors++;
            $display("FAIL latency[%0d] got %0d expected 31", i, lat);
         end
      end
   endtask

   task automatic test_back_to_back();
      int guard;
      int lat;
      ce = 1'b1;
      bus.dividend = 30'(1000);
      bus.divisor  = 16'(7);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      guard = 0;
      while (!bus.out_valid && guard < 100) begin
         tick();
         guard++;
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
             bus.quotient !== 16'd142 || bus.remainder !== 16'd6) begin
            errors++;
            $display("FAIL hold[%0d] out_valid=%b in_ready=%b q=%0d r=%0d expected 1 0 142 6",
                     i, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder);
         end
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain in_ready=%b out_valid=%b expected 1 0", bus.in_ready, bus.out_valid);
      end
      bus.dividend = 30'(-1000);
      bus.divisor  = 16'(-7);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_accept in_ready=%b expected 0", bus.in_ready);
      end
      lat = 0;
      while (!bus.out_valid && lat < 100) begin
         tick();
         lat++;
      end
      checks++;
      if (lat !== 31 || bus.quotient !== 16'd142 || bus.remainder !== 16'(-6)) begin
         errors++;
         $display("FAIL b2b_result lat=%0d q=%0d r=%0d expected 31 142 -6",
                  lat, $signed(bus.quotient), $signed(bus.remainder));
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_ce_toggle();
      int n;
      int guard;
      ce = 1'b1;
      bus.dividend = 30'(1000);
      bus.divisor  = 16'(7);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      n = 0;
      guard = 0;
      while (!bus.out_valid && guard < 400) begin
         ce = 1'($urandom_range(0, 1));
         tick();
         if (ce) n++;
         guard++;
      end
      checks++;
      if (n !== 31 || bus.quotient !== 16'd142 || bus.remainder !== 16'd6) begin
         errors++;
         $display("FAIL ce_toggle ce_cycles=%0d q=%0d r=%0d expected 31 142 6",
                  n, bus.quotient, bus.remainder);
      end
      ce = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      checks++;
      if (bus.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL ce_stall_drain out_valid=%b expected 1", bus.out_valid);
      end
      ce = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [15:0] q, r;
      logic        o, z;
      int          lat;
      int          seen;
      ce = 1'b1;
      bus.dividend = 30'(1000);
      bus.divisor  = 16'(7);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      reset = 1'b1;
      tick();
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset in_ready=%b out_valid=%b expected 0 0", bus.in_ready, bus.out_valid);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_release in_ready=%b expected 1", bus.in_ready);
      end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.out_valid) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL mid_reset_discard out_valid cycles=%0d expected 0", seen);
      end
      run_op(1000, 7, q, r, o, z, lat);
      checks++;
      if (q !== 16'd142 || r !== 16'd6 || o !== 1'b0 || z !== 1'b0 || lat !== 31) begin
         errors++;
         $display("FAIL after_reset q=%0d r=%0d ovf=%b dz=%b lat=%0d expected 142 6 0 0 31",
                  q, r, o, z, lat);
      end
   endtask

   initial begin
      test_reset();
      test_divide();
      test_back_to_back();
      test_ce_toggle();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

endmodule
